// File: rtl/logit_argmax.sv
// Serial signed argmax over the classifier logit vector, CH_PER_CYC lanes per cycle,
// with a small result FIFO drained over a valid/ready handshake.
module logit_argmax #(
   parameter int CH_IN      = 64,
   parameter int NO_CH      = 24,
   parameter int BW         = 16,
   parameter int CH_PER_CYC = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vld_in,
   input  logic [CH_IN-1:0][BW-1:0]  data_in,
   output logic                      vld_out,
   input  logic                      rdy_out,
   output logic [7:0]                class_out,
   output logic [BW-1:0]             max_out,
   output logic                      busy,
   output logic [7:0]                drop_cnt
);

   localparam int NGRP = (NO_CH + CH_PER_CYC - 1) / CH_PER_CYC;
   localparam int NPAD = NGRP * CH_PER_CYC;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int CW   = (NO_CH > 1) ? $clog2(NO_CH) : 1;
   localparam int LW   = $clog2(NPAD) + 1;
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] MOST_NEG = {1'b1, {(BW-1){1'b0}}};

   typedef enum logic {IDLE, SCAN} state_t;

   typedef struct packed {
      logic [CW-1:0] cls;
      logic [BW-1:0] val;
   } res_t;

   state_t                                 state_q, state_d;
   logic [NGRP-1:0][CH_PER_CYC-1:0][BW-1:0] frame_q, frame_d, frame_in;
   logic [BW-1:0]                          best_q, best_d;
   logic [CW-1:0]                          best_idx_q, best_idx_d;
   logic [GW-1:0]                          grp_q, grp_d;
   res_t [FIFO_DEPTH-1:0]                  mem_q, mem_d;
   logic [AW:0]                            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   res_t                                   hold_q, hold_d;
   logic [7:0]                             drop_q, drop_d;

   logic          last, accept, in_drop;
   logic          empty, full, pop, push_ok, fifo_drop;
   logic [BW-1:0] scan_best;
   logic [CW-1:0] scan_idx;
   logic [LW-1:0] lane_idx;
   logic [8:0]    drop_sum;
   res_t          head;

   // Pad lanes hold the most-negative value, so a strict > never lets them win.
   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      for (genvar j = 0; j < CH_PER_CYC; j++) begin : g_lane
         if (g * CH_PER_CYC + j < NO_CH) begin : g_real
            assign frame_in[g][j] = data_in[g * CH_PER_CYC + j];
         end else begin : g_pad
            assign frame_in[g][j] = MOST_NEG;
         end
      end
   end

   assign last    = (state_q == SCAN) && (grp_q == GW'(NGRP - 1));
   assign accept  = vld_in && ((state_q == IDLE) || last);
   assign in_drop = vld_in && (state_q == SCAN) && !last;

   // Low-to-high chain with strict > keeps the lowest index on ties.
   always_comb begin
      scan_best = best_q;
      scan_idx  = best_idx_q;
      lane_idx  = '0;
      for (int j = 0; j < CH_PER_CYC; j++) begin
         lane_idx = LW'(grp_q) * LW'(CH_PER_CYC) + LW'(j);
         if ($signed(frame_q[grp_q][j]) > $signed(scan_best)) begin
            scan_best = frame_q[grp_q][j];
            scan_idx  = CW'(lane_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vld_in) state_d = SCAN;
         SCAN:    if (last && !vld_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SCAN);
   end

   always_comb begin
      frame_d    = frame_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      grp_d      = grp_q;
      if (accept) begin
         frame_d    = frame_in;
         best_d     = MOST_NEG;
         best_idx_d = '0;
         grp_d      = '0;
      end else if (state_q == SCAN) begin
         best_d     = scan_best;
         best_idx_d = scan_idx;
         grp_d      = last ? '0 : grp_q + 1'b1;
      end
   end

   // Result FIFO; a simultaneous pop frees the slot a full-FIFO push needs.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = !empty && rdy_out;
   assign push_ok   = last && (!full || pop);
   assign fifo_drop = last && full && !pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      hold_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : hold_q;
      if (push_ok) mem_d[wr_ptr_q[AW-1:0]] = '{cls: scan_idx, val: scan_best};
      drop_sum = {1'b0, drop_q} + {8'b0, in_drop} + {8'b0, fifo_drop};
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      frame_q <= frame_d;
      mem_q   <= mem_d;
      if (rst) begin
         best_q     <= MOST_NEG;
         best_idx_q <= '0;
         grp_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         hold_q     <= '0;
         drop_q     <= '0;
      end else begin
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         grp_q      <= grp_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         hold_q     <= hold_d;
         drop_q     <= drop_d;
      end
   end

   // Empty FIFO keeps presenting the last popped result.
   assign head      = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
   assign vld_out   = !empty;
   assign class_out = 8'(head.cls);
   assign max_out   = head.val;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_logit_argmax.sv
// Scenario bench for logit_argmax: expected results queued at stimulus time,
// popped and compared by a monitor on every output handshake.
module tb_logit_argmax;

   localparam int CH_IN = 64;
   localparam int NO_CH = 24;
   localparam int BW    = 16;
   localparam int NGRP  = 6;

   typedef logic [CH_IN-1:0][BW-1:0] frame_t;
   typedef struct packed {
      logic [7:0]    c;
      logic [BW-1:0] m;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          vld_in;
   frame_t        data_in;
   logic          vld_out;
   logic          rdy_out;
   logic [7:0]    class_out;
   logic [BW-1:0] max_out;
   logic          busy;
   logic [7:0]    drop_cnt;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];
   exp_t e;

   logit_argmax #(.CH_IN(CH_IN), .NO_CH(NO_CH), .BW(BW), .CH_PER_CYC(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .vld_out(vld_out),
      .rdy_out(rdy_out), .class_out(class_out), .max_out(max_out), .busy(busy),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (rst === 1'b0 && vld_out === 1'b1 && rdy_out === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got class=%0d max=%h, expected no output", class_out, max_out);
         end else begin
            e = q.pop_front();
            if (class_out !== e.c || max_out !== e.m) begin
               failures++;
               $display("FAIL sb_result got class=%0d max=%h, expected class=%0d max=%h",
                        class_out, max_out, e.c, e.m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic frame_t fill(input logic [BW-1:0] v);
      frame_t f;
      for (int i = 0; i < CH_IN; i++) f[i] = v;
      return f;
   endfunction

   function automatic exp_t model(input frame_t f);
      exp_t r;
      r.m = 16'h8000;
      r.c = 8'd0;
      for (int i = 0; i < NO_CH; i++)
         if ($signed(f[i]) > $signed(r.m)) begin
            r.m = f[i];
            r.c = 8'(i);
         end
      return r;
   endfunction

   // Drives one frame and returns in its last scan cycle (next frame may start there).
   task automatic send(input frame_t f, input logic expect_out);
      data_in = f;
      vld_in  = 1'b1;
      if (expect_out) q.push_back(model(f));
      tick();
      vld_in = 1'b0;
      repeat (NGRP - 1) tick();
   endtask

   task automatic apply_reset();
      rst     = 1'b1;
      vld_in  = 1'b0;
      rdy_out = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      q.delete();
   endtask

   task automatic check_latency(input string name, input frame_t f);
      int first, nv, nb;
      first = -1; nv = 0; nb = 0;
      data_in = f;
      vld_in  = 1'b1;
      q.push_back(model(f));
      tick();
      vld_in = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (vld_out === 1'b1) begin
            nv++;
            if (first < 0) first = c;
         end
         if (busy === 1'b1) nb++;
         tick();
      end
      checks += 3;
      if (first !== 7) begin failures++; $display("FAIL %s_latency got %0d, expected 7", name, first); end
      if (nv !== 1)    begin failures++; $display("FAIL %s_vld_cycles got %0d, expected 1", name, nv); end
      if (nb !== 6)    begin failures++; $display("FAIL %s_busy_cycles got %0d, expected 6", name, nb); end
   endtask

   task automatic test_reset();
      apply_reset();
      checks += 5;
      if (vld_out !== 1'b0)   begin failures++; $display("FAIL rst_vld_out got %b, expected 0", vld_out); end
      if (class_out !== 8'd0) begin failures++; $display("FAIL rst_class got %0d, expected 0", class_out); end
      if (max_out !== 16'd0)  begin failures++; $display("FAIL rst_max got %h, expected 0000", max_out); end
      if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got %b, expected 0", busy); end
      if (drop_cnt !== 8'd0)  begin failures++; $display("FAIL rst_drop got %0d, expected 0", drop_cnt); end
   endtask

   task automatic test_basic();
      frame_t f;
      apply_reset();
      rdy_out = 1'b1;
      f = fill(16'hFF00);
      f[17] = 16'h0100;
      check_latency("basic", f);
   endtask

   task automatic test_ties();
      frame_t f;
      apply_reset();
      rdy_out = 1'b1;
      f = fill(16'h0000); f[3] = 16'h7FFF; f[20] = 16'h7FFF; send(f, 1'b1);
      f = fill(16'h8000);                                    send(f, 1'b1);
      f = fill(16'h0000); f[30] = 16'h7FFF;                  send(f, 1'b1);
      f = fill(16'h0000); f[23] = 16'h0001;                  send(f, 1'b1);
      f = fill(16'hFFF0); f[4] = 16'h0005; f[5] = 16'h0005;  send(f, 1'b1);
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < CH_IN; i++) f[i] = 16'($urandom);
         send(f, 1'b1);
      end
      repeat (8) tick();
      checks += 2;
      if (q.size() !== 0)    begin failures++; $display("FAIL ties_pending got %0d, expected 0", q.size()); end
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL ties_drop got %0d, expected 0", drop_cnt); end
   endtask

   task automatic test_fifo_full_drop();
      frame_t f;
      int nv;
      apply_reset();
      for (int w = 0; w < 6; w++) begin
         f = fill(16'h0000);
         f[w] = 16'h1000 + 16'(w);
         send(f, w < 4);
      end
      repeat (8) tick();
      checks += 2;
      if (drop_cnt !== 8'd2) begin failures++; $display("FAIL full_drop got %0d, expected 2", drop_cnt); end
      if (vld_out !== 1'b1)  begin failures++; $display("FAIL full_vld got %b, expected 1", vld_out); end
      rdy_out = 1'b1;
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         if (vld_out === 1'b1) nv++;
         tick();
      end
      checks += 2;
      if (nv !== 4)       begin failures++; $display("FAIL full_pops got %0d, expected 4", nv); end
      if (q.size() !== 0) begin failures++; $display("FAIL full_pending got %0d, expected 0", q.size()); end
      rdy_out = 1'b0;
   endtask

   task automatic test_push_pop_full();
      frame_t f;
      int nv;
      apply_reset();
      for (int w = 0; w < 4; w++) begin
         f = fill(16'h0000);
         f[w + 8] = 16'h2000 + 16'(w);
         send(f, 1'b1);
      end
      f = fill(16'h0000);
      f[12] = 16'h2004;
      data_in = f;
      vld_in  = 1'b1;
      q.push_back(model(f));
      tick();
      vld_in = 1'b0;
      repeat (NGRP - 1) tick();
      rdy_out = 1'b1;
      tick();
      rdy_out = 1'b0;
      tick();
      checks += 2;
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL pp_drop got %0d, expected 0", drop_cnt); end
      if (vld_out !== 1'b1)  begin failures++; $display("FAIL pp_vld got %b, expected 1", vld_out); end
      rdy_out = 1'b1;
      nv = 0;
      for (int c = 0; c < 8; c++) begin
         if (vld_out === 1'b1) nv++;
         tick();
      end
      checks += 2;
      if (nv !== 4)       begin failures++; $display("FAIL pp_pops got %0d, expected 4", nv); end
      if (q.size() !== 0) begin failures++; $display("FAIL pp_pending got %0d, expected 0", q.size()); end
      rdy_out = 1'b0;
   endtask

   task automatic test_input_drop();
      frame_t fa, fb;
      apply_reset();
      rdy_out = 1'b1;
      for (int it = 0; it < 300; it++) begin
         fa = fill(16'h0000);
         fa[it % NO_CH] = 16'h0200 + 16'(it);
         fb = fill(16'h0000);
         fb[(it + 5) % NO_CH] = 16'h7FFF;
         data_in = fa;
         vld_in  = 1'b1;
         q.push_back(model(fa));
         tick();
         vld_in = 1'b0;
         tick();
         tick();
         data_in = fb;
         vld_in  = 1'b1;
         tick();
         vld_in = 1'b0;
         tick();
         tick();
         if (it == 0) begin
            checks++;
            if (drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_one got %0d, expected 1", drop_cnt); end
         end
      end
      repeat (8) tick();
      checks += 2;
      if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got %0d, expected 255", drop_cnt); end
      if (q.size() !== 0)      begin failures++; $display("FAIL drop_pending got %0d, expected 0", q.size()); end
   endtask

   task automatic test_mid_reset();
      frame_t f;
      apply_reset();
      for (int w = 0; w < 2; w++) begin
         f = fill(16'h0000);
         f[w + 1] = 16'h0300;
         send(f, 1'b1);
      end
      f = fill(16'h0000);
      f[6] = 16'h0400;
      data_in = f;
      vld_in  = 1'b1;
      tick();
      tick();
      vld_in = 1'b0;
      checks += 3;
      if (drop_cnt !== 8'd1) begin failures++; $display("FAIL mr_pre_drop got %0d, expected 1", drop_cnt); end
      if (vld_out !== 1'b1)  begin failures++; $display("FAIL mr_pre_vld got %b, expected 1", vld_out); end
      if (busy !== 1'b1)     begin failures++; $display("FAIL mr_pre_busy got %b, expected 1", busy); end
      rst = 1'b1;
      q.delete();
      tick();
      rst = 1'b0;
      checks += 3;
      if (vld_out !== 1'b0)  begin failures++; $display("FAIL mr_vld got %b, expected 0", vld_out); end
      if (busy !== 1'b0)     begin failures++; $display("FAIL mr_busy got %b, expected 0", busy); end
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL mr_drop got %0d, expected 0", drop_cnt); end
      rdy_out = 1'b1;
      f = fill(16'hF000);
      f[9] = 16'h0010;
      check_latency("mr_fresh", f);
   endtask

   initial begin
      rst     = 1'b1;
      vld_in  = 1'b0;
      rdy_out = 1'b0;
      data_in = '0;
      test_reset();
      test_basic();
      test_ties();
      test_fifo_full_drop();
      test_push_pop_full();
      test_input_drop();
      test_mid_reset();
      repeat (4) tick();
      checks++;
      if (q.size() !== 0) begin failures++; $display("FAIL final_pending got %0d, expected 0", q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
